// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the arbiter and the FIFO.
// The slave modport is the arbiter's view. The master modport is the environment's
// view: the producers together with the FIFO controller's full flag.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] din;
    logic [NUM_REQ-1:0]            ack;
    logic                          fifo_full;
    logic                          fifo_wr;
    logic [DATA_WIDTH-1:0]         fifo_wdata;

    modport slave (
        input  req, din, fifo_full,
        output ack, fifo_wr, fifo_wdata
    );

    modport master (
        output req, din, fifo_full,
        input  ack, fifo_wr, fifo_wdata
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Each grant is a burst of up to BURST_LEN words. A burst-end write hands
// over to the next requester in the same cycle, so there is no bubble. A full
// FIFO stalls the owner without consuming burst credit.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    fifo_wr_arbiter_if.slave           bus,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic                       o_busy
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_owner;
    logic [ID_W-1:0]    r_last;
    logic [CNT_W-1:0]   r_cnt;

    state_t             w_state_nxt;
    logic [ID_W-1:0]    w_owner_nxt;
    logic [ID_W-1:0]    w_last_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic [DATA_WIDTH-1:0] w_din_lane [NUM_REQ];
    logic [NUM_REQ-1:0]    w_owner_oh;
    logic [NUM_REQ-1:0]    w_cand;
    logic                  w_in_burst;
    logic                  w_req_owner;
    logic                  w_wr_ok;
    logic                  w_burst_end;

    // First set bit of mask, searching upward from base+1 with wrap-around.
    // The search ends on base itself, so a lone request from base re-grants base.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] mask,
        input logic [ID_W-1:0]    base
    );
        logic [ID_W-1:0] result;
        logic [ID_W-1:0] idx;
        logic            found;
        result = base;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(base) + k) % NUM_REQ);
            if (!found && mask[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign w_din_lane[i] = bus.din[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_in_burst  = (r_state == ST_BURST);
    assign w_owner_oh  = NUM_REQ'(1) << r_owner;
    assign w_req_owner = bus.req[r_owner];
    // fifo_full is already registered by the FIFO controller, so gating the
    // strobe with it combinationally can never write into a full FIFO.
    assign w_wr_ok     = w_in_burst && w_req_owner && !bus.fifo_full;
    assign w_burst_end = w_wr_ok && (r_cnt == CNT_W'(BURST_LEN - 1));
    // The owner that just finished its burst competes only if nobody else asks.
    assign w_cand      = w_burst_end ? (bus.req & ~w_owner_oh) : bus.req;

    assign bus.fifo_wr    = w_wr_ok;
    assign bus.ack        = w_wr_ok ? w_owner_oh : '0;
    assign bus.fifo_wdata = w_in_burst ? w_din_lane[r_owner] : '0;
    assign o_grant        = w_in_burst ? w_owner_oh : '0;
    assign o_grant_id     = r_owner;
    assign o_busy         = w_in_burst;

    // Next-state logic: grant in IDLE, count/release/hand over in BURST.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch,
        // and combinational blocks use blocking '=' while the state register uses '<='.
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (|bus.req) begin
                    w_owner_nxt = rr_pick(bus.req, r_last);
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!w_req_owner || w_burst_end) begin
                    // Release: either the burst is spent or the owner walked away.
                    w_last_nxt = r_owner;
                    w_cnt_nxt  = '0;
                    if (|w_cand) begin
                        w_owner_nxt = rr_pick(w_cand, r_owner);
                    end else if (!w_burst_end) begin
                        w_state_nxt = ST_IDLE;
                    end
                    // Otherwise a burst-end owner that still requests keeps the grant.
                end else if (w_wr_ok) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
                // A full stall falls through with everything held.
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset restarts arbitration at requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_cnt   <= '0;
            r_last  <= ID_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: one instance with BURST_LEN=4 for the
// single/stall/drop/re-grant/reset scenarios and one with BURST_LEN=2 for rotation.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [3:0] req;
        logic       full;
        logic       busy;
        logic [1:0] gid;
        logic       wr;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus4 ();
    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus2 ();

    logic [3:0] g4, g2;
    logic [1:0] id4, id2;
    logic       b4, b2;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(4)) u_dut4 (
        .clk(clk), .reset(reset), .bus(bus4),
        .o_grant(g4), .o_grant_id(id4), .o_busy(b4)
    );

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .o_grant(g2), .o_grant_id(id2), .o_busy(b2)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int base4 [4];
    int n4    [4];
    int n2    [4];

    function automatic vec_t mk(input logic [3:0] req, input logic full, input logic busy,
                                input logic [1:0] gid, input logic wr);
        vec_t v;
        v.req = req; v.full = full; v.busy = busy; v.gid = gid; v.wr = wr;
        return v;
    endfunction

    // Requester i presents base4[i] + (words already accepted from i).
    task automatic drive4(input logic [3:0] req, input logic full);
        for (int i = 0; i < 4; i++) bus4.din[i*DW +: DW] = 8'(base4[i] + n4[i]);
        bus4.req       = req;
        bus4.fifo_full = full;
    endtask

    // Rotation requesters present {i+1, word count} in each nibble.
    task automatic drive2(input logic [3:0] req);
        for (int i = 0; i < 4; i++) bus2.din[i*DW +: DW] = 8'((i + 1) * 16 + n2[i]);
        bus2.req       = req;
        bus2.fifo_full = 1'b0;
    endtask

    task automatic set_base4(input int b0, input int b1, input int b2, input int b3);
        base4[0] = b0; base4[1] = b1; base4[2] = b2; base4[3] = b3;
        for (int i = 0; i < 4; i++) n4[i] = 0;
    endtask

    // Expected {wr, ack, wdata, grant, busy, id} for one cycle.
    function automatic logic [19:0] exp4(input vec_t v);
        logic [3:0] oh;
        logic [7:0] wd;
        oh = 4'b0001 << v.gid;
        wd = v.busy ? 8'(base4[v.gid] + n4[v.gid]) : 8'h00;
        return {v.wr, v.wr ? oh : 4'b0000, wd, v.busy ? oh : 4'b0000, v.busy, v.busy ? v.gid : 2'd0};
    endfunction

    function automatic logic [19:0] obs4(input vec_t v);
        return {bus4.fifo_wr, bus4.ack, bus4.fifo_wdata, g4, b4, v.busy ? id4 : 2'd0};
    endfunction

    function automatic logic [19:0] exp2(input vec_t v);
        logic [3:0] oh;
        logic [7:0] wd;
        oh = 4'b0001 << v.gid;
        wd = v.busy ? 8'((int'(v.gid) + 1) * 16 + n2[v.gid]) : 8'h00;
        return {v.wr, v.wr ? oh : 4'b0000, wd, v.busy ? oh : 4'b0000, v.busy, v.busy ? v.gid : 2'd0};
    endfunction

    function automatic logic [19:0] obs2(input vec_t v);
        return {bus2.fifo_wr, bus2.ack, bus2.fifo_wdata, g2, b2, v.busy ? id2 : 2'd0};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin base4[i] = 0; n4[i] = 0; n2[i] = 0; end
        drive4(4'hF, 1'b0);
        drive2(4'hF);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec += 2;
            if ({bus4.fifo_wr, bus4.ack, bus4.fifo_wdata, g4, id4, b4} !== '0) begin
                n_miss++;
                $display("FAIL reset4[%0d]: got wr=%b ack=%b wdata=%h grant=%b id=%0d busy=%b want all 0",
                         k, bus4.fifo_wr, bus4.ack, bus4.fifo_wdata, g4, id4, b4);
            end
            if ({bus2.fifo_wr, bus2.ack, bus2.fifo_wdata, g2, id2, b2} !== '0) begin
                n_miss++;
                $display("FAIL reset2[%0d]: got wr=%b ack=%b wdata=%h grant=%b id=%0d busy=%b want all 0",
                         k, bus2.fifo_wr, bus2.ack, bus2.fifo_wdata, g2, id2, b2);
            end
            @(negedge clk);
            #1;
        end
        drive4(4'h0, 1'b0);
        drive2(4'h0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Requester 2 alone writes A1, A2, A3, then drops req; arbiter returns to IDLE.
    task automatic test_single();
        vec_t tbl [$];
        set_base4(0, 0, 8'hA1, 0);
        tbl.push_back(mk(4'b0100, 1'b0, 1'b0, 2'd0, 1'b0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b0100, 1'b0, 1'b1, 2'd2, 1'b1));
        tbl.push_back(mk(4'b0000, 1'b0, 1'b1, 2'd2, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0));
        for (int c = 0; c < tbl.size(); c++) begin
            drive4(tbl[c].req, tbl[c].full);
            #1;
            n_vec++;
            if (obs4(tbl[c]) !== exp4(tbl[c])) begin
                n_miss++;
                $display("FAIL single[%0d]: got %b want %b {wr,ack,wdata,grant,busy,id}",
                         c, obs4(tbl[c]), exp4(tbl[c]));
            end
            if (tbl[c].wr) n4[tbl[c].gid]++;
            @(negedge clk);
        end
    endtask

    // All four request continuously with BURST_LEN=2: 0,0,1,1,2,2,3,3,0,0 with no bubbles.
    task automatic test_rotation();
        vec_t v;
        for (int c = 0; c < 13; c++) begin
            v.req  = (c < 11) ? 4'hF : 4'h0;
            v.full = 1'b0;
            v.busy = (c >= 1) && (c <= 11);
            v.wr   = (c >= 1) && (c <= 10);
            v.gid  = (c == 11) ? 2'd1 : 2'((c - 1) / 2);
            drive2(v.req);
            #1;
            n_vec++;
            if (obs2(v) !== exp2(v)) begin
                n_miss++;
                $display("FAIL rotation[%0d]: got %b want %b {wr,ack,wdata,grant,busy,id}",
                         c, obs2(v), exp2(v));
            end
            if (v.wr) n2[v.gid]++;
            @(negedge clk);
        end
    endtask

    // Owner 1 stalls at cnt=1 for 5 full cycles; its remaining three words
    // still fit in the burst, then requester 3 takes over without a bubble.
    task automatic test_full_stall();
        vec_t tbl [$];
        set_base4(0, 8'h50, 0, 8'h70);
        tbl.push_back(mk(4'b0010, 1'b0, 1'b0, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0010, 1'b0, 1'b1, 2'd1, 1'b1));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(4'b1010, 1'b1, 1'b1, 2'd1, 1'b0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b1010, 1'b0, 1'b1, 2'd1, 1'b1));
        tbl.push_back(mk(4'b1000, 1'b0, 1'b1, 2'd3, 1'b1));
        tbl.push_back(mk(4'b0000, 1'b0, 1'b1, 2'd3, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0));
        for (int c = 0; c < tbl.size(); c++) begin
            drive4(tbl[c].req, tbl[c].full);
            #1;
            n_vec++;
            if (obs4(tbl[c]) !== exp4(tbl[c])) begin
                n_miss++;
                $display("FAIL full_stall[%0d]: got %b want %b {wr,ack,wdata,grant,busy,id}",
                         c, obs4(tbl[c]), exp4(tbl[c]));
            end
            if (tbl[c].wr) n4[tbl[c].gid]++;
            @(negedge clk);
        end
    endtask

    // Owner 0 abandons after one word: one bubble, then requester 3 (1 and 2 idle).
    task automatic test_early_drop();
        vec_t tbl [$];
        set_base4(8'h20, 0, 0, 8'h80);
        tbl.push_back(mk(4'b1001, 1'b0, 1'b0, 2'd0, 1'b0));
        tbl.push_back(mk(4'b1001, 1'b0, 1'b1, 2'd0, 1'b1));
        tbl.push_back(mk(4'b1000, 1'b0, 1'b1, 2'd0, 1'b0));
        tbl.push_back(mk(4'b1000, 1'b0, 1'b1, 2'd3, 1'b1));
        tbl.push_back(mk(4'b1000, 1'b0, 1'b1, 2'd3, 1'b1));
        tbl.push_back(mk(4'b0000, 1'b0, 1'b1, 2'd3, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0));
        for (int c = 0; c < tbl.size(); c++) begin
            drive4(tbl[c].req, tbl[c].full);
            #1;
            n_vec++;
            if (obs4(tbl[c]) !== exp4(tbl[c])) begin
                n_miss++;
                $display("FAIL early_drop[%0d]: got %b want %b {wr,ack,wdata,grant,busy,id}",
                         c, obs4(tbl[c]), exp4(tbl[c]));
            end
            if (tbl[c].wr) n4[tbl[c].gid]++;
            @(negedge clk);
        end
    endtask

    // Lone requester 1 streams 10 words across burst boundaries without a gap.
    task automatic test_self_regrant();
        vec_t tbl [$];
        set_base4(0, 8'h90, 0, 0);
        tbl.push_back(mk(4'b0010, 1'b0, 1'b0, 2'd0, 1'b0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(4'b0010, 1'b0, 1'b1, 2'd1, 1'b1));
        tbl.push_back(mk(4'b0000, 1'b0, 1'b1, 2'd1, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0));
        for (int c = 0; c < tbl.size(); c++) begin
            drive4(tbl[c].req, tbl[c].full);
            #1;
            n_vec++;
            if (obs4(tbl[c]) !== exp4(tbl[c])) begin
                n_miss++;
                $display("FAIL self_regrant[%0d]: got %b want %b {wr,ack,wdata,grant,busy,id}",
                         c, obs4(tbl[c]), exp4(tbl[c]));
            end
            if (tbl[c].wr) n4[tbl[c].gid]++;
            @(negedge clk);
        end
    endtask

    // Reset asserted between clock edges while requester 2 owns a burst;
    // afterwards arbitration starts again from requester 0.
    task automatic test_reset_mid_burst();
        vec_t tbl [$];
        set_base4(0, 0, 8'hC0, 0);
        tbl.push_back(mk(4'b0100, 1'b0, 1'b0, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0100, 1'b0, 1'b1, 2'd2, 1'b1));
        for (int c = 0; c < tbl.size(); c++) begin
            drive4(tbl[c].req, tbl[c].full);
            #1;
            n_vec++;
            if (obs4(tbl[c]) !== exp4(tbl[c])) begin
                n_miss++;
                $display("FAIL reset_pre[%0d]: got %b want %b {wr,ack,wdata,grant,busy,id}",
                         c, obs4(tbl[c]), exp4(tbl[c]));
            end
            if (tbl[c].wr) n4[tbl[c].gid]++;
            @(negedge clk);
        end
        drive4(4'b0100, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({bus4.fifo_wr, bus4.ack, bus4.fifo_wdata, g4, id4, b4} !== '0) begin
            n_miss++;
            $display("FAIL reset_async: got wr=%b ack=%b wdata=%h grant=%b id=%0d busy=%b want all 0",
                     bus4.fifo_wr, bus4.ack, bus4.fifo_wdata, g4, id4, b4);
        end
        @(negedge clk);
        reset = 1'b0;
        set_base4(8'h40, 8'h60, 0, 0);
        tbl.delete();
        tbl.push_back(mk(4'b0011, 1'b0, 1'b0, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0011, 1'b0, 1'b1, 2'd0, 1'b1));
        tbl.push_back(mk(4'b0010, 1'b0, 1'b1, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0010, 1'b0, 1'b1, 2'd1, 1'b1));
        tbl.push_back(mk(4'b0000, 1'b0, 1'b1, 2'd1, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0));
        for (int c = 0; c < tbl.size(); c++) begin
            drive4(tbl[c].req, tbl[c].full);
            #1;
            n_vec++;
            if (obs4(tbl[c]) !== exp4(tbl[c])) begin
                n_miss++;
                $display("FAIL reset_post[%0d]: got %b want %b {wr,ack,wdata,grant,busy,id}",
                         c, obs4(tbl[c]), exp4(tbl[c]));
            end
            if (tbl[c].wr) n4[tbl[c].gid]++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_full_stall();
        test_early_drop();
        test_self_regrant();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
